text_pixel_gen: RTL and testbench
=================================

Name: text_pixel_gen

Overview:
Text-mode pixel back end, directly downstream of the VGA timing generator. It consumes the timing strobes (fetch_cell, fetch_font, load_nshift, cell_addr, vga_blank) and owns the character-cell RAM, with a host write port. It drives an external synchronous font ROM, serialises glyph bits through an 8-bit shift register and maps fg/bg attributes through a fixed 16-entry RGB444 palette to produce vga_r/g/b.

Parameters:
CELL_DEPTH, 2400, number of cells implemented in cell RAM (80x30); addresses >= CELL_DEPTH are unimplemented.
BLANK_DELAY, 2, pipeline stages applied to vga_blank so it aligns with pixel output.
CURSOR_ROW, 14, first glyph row drawn as cursor (TEXT_CURSOR_EN only).

Ports:
clk_vga  in  1  pixel clock; all logic on rising edge
rst_vga  in  1  asynchronous, active-high reset
fetch_cell  in  1  read cell RAM at cell_addr this cycle
fetch_font  in  1  latch font address/attributes from last cell read
load_nshift  in  1  1 = load shift register from font_data, 0 = shift
cell_addr  in  12  cell index from timing generator
glyph_row  in  4  scanline within glyph (0..15)
vga_blank  in  1  1 = outside active area
font_addr  out  12  {char[7:0], glyph_row[3:0]} to font ROM
font_data  in  8  ROM data, valid one cycle after font_addr changes; bit 7 = leftmost pixel
host_we  in  1  cell RAM write strobe
host_addr  in  12  cell RAM write address
host_wdata  in  16  cell word: [7:0] char, [11:8] fg index, [15:12] bg index
vga_r / vga_g / vga_b  out  4 each  pixel colour

Behaviour:
- Reset (async): font_addr, shift reg, cell_q, attr_pending, attr_cur, blank pipe (forced to 1), vga_r/g/b all cleared to 0. Cell RAM contents not reset. Reset mid-line: outputs 0 immediately; the next load_nshift after release restarts cleanly.
- Cell read: fetch_cell in cycle N -> cell_q valid from N+1; cell_q held until next fetch_cell. cell_addr >= CELL_DEPTH reads 16'h0000.
- Host write: host_we writes host_wdata at host_addr; ignored if host_addr >= CELL_DEPTH. Simultaneous write and read of the same address: read returns the old word (read-before-write).
- fetch_font in cycle M (M >= N+1): font_addr <= {cell_q[7:0], glyph_row}; attr_pending <= cell_q[15:8]. ROM returns font_data in M+2.
- load_nshift (cycle >= M+2): shift <= font_data, attr_cur <= attr_pending. Otherwise shift <= {shift[6:0], 1'b0}. Simultaneous fetch_font and load_nshift are legal: the load uses the current font_data and the current attr_pending, and the fetch updates pending for the next cell.
- Colour: idx = shift[7] ? attr_cur[3:0] : attr_cur[7:4]. The RGB output is registered, so there is one cycle from shift[7] to vga_r/g/b. If the delayed blank (vga_blank through BLANK_DELAY flops) is 1, the output is 0.
- Palette (RGB hex): 0 000, 1 00A, 2 0A0, 3 0AA, 4 A00, 5 A0A, 6 A50, 7 AAA, 8 555, 9 55F, A 5F5, B 5FF, C F55, D F5F, E FF5, F FFF.
- No FSM beyond the fetch/load pipeline. Strobes arriving out of order produce stale data, never a lockup.

Optional Feature:
TEXT_CURSOR_EN:
- Defined: adds inputs cursor_addr[11:0], cursor_on, vga_frame[8:1].
  - cell_addr is carried alongside cell_q and attr_pending.
  - At load_nshift the block swaps fg/bg for the cell when all of the following hold: the carried address == cursor_addr, cursor_on = 1, glyph_row >= CURSOR_ROW, and vga_frame[5] = 1.
- Undefined: these ports are absent and there is no swap logic.

Test Plan:
1. Reset asserted mid-pixel -> vga_r/g/b = 0 and font_addr = 0 in the same cycle; after release with vga_blank = 1, outputs stay 0.
2. Host writes 16'h1F41 at addr 0. Then fetch_cell@0, fetch_font@+1 with glyph_row = 3, and ROM returns 8'hA5 -> font_addr = 12'h413. After load, 8 pixels = F,1,F,1,1,F,1,F as RGB FFF/00A (vga_b = A for bg pixels).
3. Read addr 2400 after host write to 2400 -> cell_q = 0; font_addr char = 8'h00; bg/fg index 0 -> black.
4. host_we and fetch_cell on the same address 5, same cycle: old 16'h0741 -> new 16'h0E42 -> first read returns 0741, next read returns 0E42.
5. vga_blank toggled 1 -> 0 at cycle T -> first non-zero pixel appears at T + BLANK_DELAY, aligned with shift[7] of the first loaded glyph.
6. (TEXT_CURSOR_EN) cursor_addr = 0, cursor_on = 1, vga_frame[5] = 1, glyph_row = 14, attr 8'h1F, font 8'hFF -> output 00A for all 8 pixels. Repeat with glyph_row = 13 -> output FFF for all 8 pixels.

Source files
------------

// File: rtl/text_pixel_gen.sv
// Text-mode pixel back end: cell RAM, font fetch, glyph shifter and palette.
// Optional TEXT_CURSOR_EN adds a blinking block cursor by swapping fg/bg.
module text_pixel_gen #(
  parameter int CELL_DEPTH  = 2400,
  parameter int BLANK_DELAY = 2,
  parameter int CURSOR_ROW  = 14
) (
  input  logic        clk_vga_i,
  input  logic        rst_vga_i,
  input  logic        fetch_cell_i,
  input  logic        fetch_font_i,
  input  logic        load_nshift_i,
  input  logic [11:0] cell_addr_i,
  input  logic [3:0]  glyph_row_i,
  input  logic        vga_blank_i,
  output logic [11:0] font_addr_o,
  input  logic [7:0]  font_data_i,
  input  logic        host_we_i,
  input  logic [11:0] host_addr_i,
  input  logic [15:0] host_wdata_i,
`ifdef TEXT_CURSOR_EN
  input  logic [11:0] cursor_addr_i,
  input  logic        cursor_on_i,
  input  logic [8:1]  vga_frame_i,
`endif
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o
);

  localparam logic [12:0] DEPTH_W = 13'(CELL_DEPTH);

  logic [15:0] cell_mem [CELL_DEPTH];

  logic [15:0] cell_q, cell_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic [7:0]  attr_pend_q, attr_pend_d;
  logic [7:0]  attr_cur_q, attr_cur_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] rgb_q, rgb_d;
  logic [BLANK_DELAY-1:0] blank_q;

  logic        rd_ok, wr_ok, swap;
  logic [15:0] rd_word;

  function automatic logic [11:0] palette(input logic [3:0] idx);
    logic [11:0] c;
    case (idx)
      4'h0: c = 12'h000;  4'h1: c = 12'h00A;  4'h2: c = 12'h0A0;  4'h3: c = 12'h0AA;
      4'h4: c = 12'hA00;  4'h5: c = 12'hA0A;  4'h6: c = 12'hA50;  4'h7: c = 12'hAAA;
      4'h8: c = 12'h555;  4'h9: c = 12'h55F;  4'hA: c = 12'h5F5;  4'hB: c = 12'h5FF;
      4'hC: c = 12'hF55;  4'hD: c = 12'hF5F;  4'hE: c = 12'hFF5;  default: c = 12'hFFF;
    endcase
    return c;
  endfunction

  assign rd_ok = ({1'b0, cell_addr_i} < DEPTH_W);
  assign wr_ok = ({1'b0, host_addr_i} < DEPTH_W);

  // Cell RAM is not reset; a same-cycle write is seen only by later reads.
  always_ff @(posedge clk_vga_i) begin
    if (host_we_i && wr_ok) cell_mem[host_addr_i] <= host_wdata_i;
  end

`ifdef TEXT_CURSOR_EN
  localparam logic [3:0] CUR_ROW = 4'(CURSOR_ROW);
  logic [11:0] cell_ad_q, pend_ad_q;
  logic        unused_frame;
  assign unused_frame = ^{vga_frame_i[8:6], vga_frame_i[4:1]};
  assign swap = (pend_ad_q == cursor_addr_i) && cursor_on_i &&
                (glyph_row_i >= CUR_ROW) && vga_frame_i[5];

  always_ff @(posedge clk_vga_i or posedge rst_vga_i) begin
    if (rst_vga_i) begin
      cell_ad_q <= '0;
      pend_ad_q <= '0;
    end else begin
      if (fetch_cell_i) cell_ad_q <= cell_addr_i;
      if (fetch_font_i) pend_ad_q <= cell_ad_q;
    end
  end
`else
  assign swap = 1'b0;
`endif

  always_comb begin
    rd_word     = '0;
    cell_d      = cell_q;
    font_addr_d = font_addr_q;
    attr_pend_d = attr_pend_q;
    attr_cur_d  = attr_cur_q;
    shift_d     = {shift_q[6:0], 1'b0};
    rgb_d       = palette(shift_q[7] ? attr_cur_q[3:0] : attr_cur_q[7:4]);
    if (rd_ok) rd_word = cell_mem[cell_addr_i];
    if (fetch_cell_i) cell_d = rd_word;
    if (fetch_font_i) begin
      font_addr_d = {cell_q[7:0], glyph_row_i};
      attr_pend_d = cell_q[15:8];
    end
    // Load consumes the pending attribute before a same-cycle fetch replaces it.
    if (load_nshift_i) begin
      shift_d    = font_data_i;
      attr_cur_d = swap ? {attr_pend_q[3:0], attr_pend_q[7:4]} : attr_pend_q;
    end
  end

  always_ff @(posedge clk_vga_i or posedge rst_vga_i) begin
    if (rst_vga_i) begin
      cell_q      <= '0;
      font_addr_q <= '0;
      attr_pend_q <= '0;
      attr_cur_q  <= '0;
      shift_q     <= '0;
      rgb_q       <= '0;
      blank_q     <= '1;
    end else begin
      cell_q      <= cell_d;
      font_addr_q <= font_addr_d;
      attr_pend_q <= attr_pend_d;
      attr_cur_q  <= attr_cur_d;
      shift_q     <= shift_d;
      rgb_q       <= rgb_d;
      blank_q[0]  <= vga_blank_i;
      for (int i = 1; i < BLANK_DELAY; i++) blank_q[i] <= blank_q[i-1];
    end
  end

  assign font_addr_o = font_addr_q;
  assign vga_r_o = blank_q[BLANK_DELAY-1] ? 4'h0 : rgb_q[11:8];
  assign vga_g_o = blank_q[BLANK_DELAY-1] ? 4'h0 : rgb_q[7:4];
  assign vga_b_o = blank_q[BLANK_DELAY-1] ? 4'h0 : rgb_q[3:0];

endmodule

// File: tb/tb_text_pixel_gen.sv
// Bench for text_pixel_gen: synchronous font ROM model, cell-word model and
// a per-pixel expected queue built from the glyph/palette rules.
module tb_text_pixel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_cell, fetch_font, load_nshift, vga_blank;
  logic [11:0] cell_addr;
  logic [3:0]  glyph_row;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        host_we;
  logic [11:0] host_addr;
  logic [15:0] host_wdata;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef TEXT_CURSOR_EN
  logic [11:0] cursor_addr;
  logic        cursor_on;
  logic [8:1]  vga_frame;
`endif

  text_pixel_gen dut (
    .clk_vga_i(clk), .rst_vga_i(rst),
    .fetch_cell_i(fetch_cell), .fetch_font_i(fetch_font), .load_nshift_i(load_nshift),
    .cell_addr_i(cell_addr), .glyph_row_i(glyph_row), .vga_blank_i(vga_blank),
    .font_addr_o(font_addr), .font_data_i(font_data),
    .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
`ifdef TEXT_CURSOR_EN
    .cursor_addr_i(cursor_addr), .cursor_on_i(cursor_on), .vga_frame_i(vga_frame),
`endif
    .vga_r_o(vga_r), .vga_g_o(vga_g), .vga_b_o(vga_b)
  );

  // clock / ROM
  always #5 clk = ~clk;

  logic [7:0]  rom [4096];
  always @(posedge clk) font_data <= rom[font_addr];

  // model state and scoreboard
  logic [15:0] mem_model [4096];
  logic [11:0] pal [16];
  logic [11:0] exp_q[$];
  logic [11:0] cell_a [16];
  logic [3:0]  row_a [16];
  logic [15:0] word_a [16];
  logic        blank_a [200];
  logic [11:0] obs [200];
  logic [11:0] fa_obs [200];
  int          n_vec = 0;
  int          n_err = 0;
  int          blank_t0 = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_read(input logic [11:0] a);
    return (a < 12'd2400) ? mem_model[a] : 16'h0000;
  endfunction

  function automatic logic [11:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  task automatic clear_strobes();
    fetch_cell = 0; fetch_font = 0; load_nshift = 0; host_we = 0;
  endtask

  task automatic host_write(input logic [11:0] a, input logic [15:0] d);
    host_we = 1; host_addr = a; host_wdata = d;
    tick();
    host_we = 0;
    if (a < 12'd2400) mem_model[a] = d;
  endtask

  // Push the 8 pixels a cell should produce, colours looked up by index.
  task automatic push_cell(input int k);
    logic [15:0] w;
    logic [7:0]  g;
    logic [3:0]  fg, bg, tmp;
    w  = word_a[k];
    fg = w[11:8];
    bg = w[15:12];
    g  = rom[{w[7:0], row_a[k]}];
`ifdef TEXT_CURSOR_EN
    if (cell_a[k] == cursor_addr && cursor_on && glyph_row >= 4'd14 && vga_frame[5]) begin
      tmp = fg; fg = bg; bg = tmp;
    end
`else
    tmp = 4'h0;
`endif
    for (int i = 0; i < 8; i++) exp_q.push_back(g[7-i] ? pal[fg] : pal[bg]);
  endtask

  // Streams n cells back to back, 8 pixels each, fetches overlapping loads.
  // blank_mode: 0 = never blank, 1 = random blanking, 2 = blank until blank_t0.
  task automatic run_stream(input int n, input int blank_mode, input bit wr_rand);
    int s, k, fc_k, ff_k;
    logic [11:0] e;
    exp_q.delete();
    for (int t = 0; t <= 3 + 8*n; t++) begin
      clear_strobes();
      case (blank_mode)
        0: vga_blank = 0;
        1: vga_blank = ($urandom_range(3) == 0);
        default: vga_blank = (t < blank_t0);
      endcase
      blank_a[t] = vga_blank;
      fc_k = -1; ff_k = -1;
      if (t == 0) fc_k = 0;
      if (t == 1) ff_k = 0;
      if (t == 2 && n > 1) fc_k = 1;
      if (t >= 3) begin
        s = (t - 3) % 8;
        k = (t - 3) / 8;
        if (k < n && s == 0 && k + 1 < n) ff_k = k + 1;
        if (k < n && s == 7 && k + 2 < n) fc_k = k + 2;
      end
      if (fc_k >= 0) begin
        fetch_cell = 1;
        cell_addr  = cell_a[fc_k];
        word_a[fc_k] = model_read(cell_a[fc_k]);
      end
      if (ff_k >= 0) begin
        fetch_font = 1;
        glyph_row  = row_a[ff_k];
      end
      if (t >= 3 && (t - 3) % 8 == 0 && (t - 3) / 8 < n) begin
        load_nshift = 1;
        push_cell((t - 3) / 8);
      end
      if (wr_rand && $urandom_range(3) == 0) begin
        host_we    = 1;
        host_addr  = ($urandom_range(7) == 0) ? 12'($urandom_range(2400, 4095)) : 12'($urandom_range(63));
        host_wdata = 16'($urandom);
        if (host_addr < 12'd2400) mem_model[host_addr] = host_wdata;
      end
      tick();
      fa_obs[t] = font_addr;
      if (t >= 4) begin
        e = exp_q.pop_front();
        if (blank_a[t-1]) e = 12'h000;
        obs[t-4] = rgb();
        check_val("pixel", obs[t-4], e);
      end
    end
    clear_strobes();
  endtask

  initial begin
    rst = 1; vga_blank = 1; cell_addr = 0; glyph_row = 0;
    host_addr = 0; host_wdata = 0;
    clear_strobes();
`ifdef TEXT_CURSOR_EN
    cursor_addr = 0; cursor_on = 0; vga_frame = 0;
`endif
    pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
      mem_model[i] = 16'h0000;
    end
    rom[12'h413] = 8'hA5;
    tick(); tick(); tick();
    check_val("reset_rgb", {4'h0, rgb()}, 16'h0000);
    check_val("reset_font_addr", {4'h0, font_addr}, 16'h0000);
    rst = 0;
    vga_blank = 0;
    for (int a = 0; a < 64; a++) host_write(12'(a), 16'($urandom));
    for (int a = 0; a < 64; a++) host_write(12'(2400 + a), 16'($urandom));

    // single cell: attr 1F, char 41, glyph A5
    host_write(12'd0, 16'h1F41);
    cell_a[0] = 12'd0; row_a[0] = 4'd3;
    run_stream(1, 0, 0);
    check_val("font_addr_413", {4'h0, fa_obs[1]}, 16'h0413);
    check_val("px0_fff", {4'h0, obs[0]}, 16'h0FFF);
    check_val("px1_00a", {4'h0, obs[1]}, 16'h000A);
    check_val("px4_00a", {4'h0, obs[4]}, 16'h000A);
    check_val("px7_fff", {4'h0, obs[7]}, 16'h0FFF);

    // unimplemented address reads zero even after a write
    host_write(12'd2400, 16'hFFFF);
    cell_a[0] = 12'd2400; row_a[0] = 4'd7;
    run_stream(1, 0, 0);
    check_val("oob_font_addr", {4'h0, fa_obs[1]}, 16'h0007);
    for (int i = 0; i < 8; i++) check_val("oob_black", {4'h0, obs[i]}, 16'h0000);

    // read-before-write on the same address
    host_write(12'd5, 16'h0741);
    host_we = 1; host_addr = 12'd5; host_wdata = 16'h0E42;
    fetch_cell = 1; cell_addr = 12'd5;
    tick();
    mem_model[5] = 16'h0E42;
    clear_strobes();
    fetch_font = 1; glyph_row = 4'd2;
    tick();
    check_val("rbw_old", {4'h0, font_addr}, 16'h0412);
    clear_strobes();
    fetch_cell = 1;
    tick();
    clear_strobes();
    fetch_font = 1;
    tick();
    check_val("rbw_new", {4'h0, font_addr}, 16'h0422);
    clear_strobes();

    // blank release alignment, all-white cell
    host_write(12'd10, 16'hFF41);
    cell_a[0] = 12'd10; row_a[0] = 4'd0;
    blank_t0 = 5;
    run_stream(1, 2, 0);
    check_val("blank_px0", {4'h0, obs[0]}, 16'h0000);
    check_val("blank_px1", {4'h0, obs[1]}, 16'h0000);
    check_val("blank_px2", {4'h0, obs[2]}, 16'h0FFF);

    // async reset in the middle of a lit pixel
    vga_blank = 0;
    fetch_cell = 1; cell_addr = 12'd10; tick(); clear_strobes();
    fetch_font = 1; tick(); clear_strobes();
    tick();
    load_nshift = 1; tick(); clear_strobes();
    tick();
    check_val("pre_reset_lit", {4'h0, rgb()}, 16'h0FFF);
    #2 rst = 1;
    #1;
    check_val("async_rst_rgb", {4'h0, rgb()}, 16'h0000);
    check_val("async_rst_font", {4'h0, font_addr}, 16'h0000);
    vga_blank = 1;
    tick();
    #3 rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_rst_blank", {4'h0, rgb()}, 16'h0000);
    end
    vga_blank = 0;

`ifdef TEXT_CURSOR_EN
    host_write(12'd0, 16'h1FC3);
    rom[{8'hC3, 4'd14}] = 8'hFF;
    rom[{8'hC3, 4'd13}] = 8'hFF;
    cursor_addr = 12'd0; cursor_on = 1; vga_frame = 8'h10;
    cell_a[0] = 12'd0; row_a[0] = 4'd14;
    run_stream(1, 0, 0);
    for (int i = 0; i < 8; i++) check_val("cursor_row14", {4'h0, obs[i]}, 16'h000A);
    row_a[0] = 4'd13;
    run_stream(1, 0, 0);
    for (int i = 0; i < 8; i++) check_val("cursor_row13", {4'h0, obs[i]}, 16'h0FFF);
    cursor_on = 0;
`endif

    // randomized back-to-back streams with background host writes
    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(2, 8);
      for (int k = 0; k < n; k++) begin
        cell_a[k] = ($urandom_range(7) == 0) ? 12'($urandom_range(2400, 4095)) : 12'($urandom_range(63));
        row_a[k]  = 4'($urandom_range(15));
      end
      run_stream(n, 1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
